random_walk_filter: RTL and testbench
=====================================

# random_walk_filter

Parametrised random-walk (K-counter) loop filter for the digital PLL, sitting between the phase detector and the DCO/divider control. It has a configurable counter width and a runtime-programmable modulus K. It integrates lead/lag pulses and emits registered one-cycle carry/borrow pulses when the walk reaches ±K, then reloads a programmable start value. An integrated lock detector asserts when a configurable number of phase events pass without a carry or borrow.

## Interface
- WIDTH, 5: signed counter width; legal K range is 1..2^(WIDTH-1)-1.
- LOCK_WINDOW, 16: quiet phase events required for lock; must be ≥1.
- clk_i  in  1  system clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- clear_i  in  1  synchronous clear/reload; highest priority below reset.
- enable_i  in  1  qualifies increment_i/decrement_i; low = hold all state.
- increment_i  in  1  lead pulse from the phase detector (+1).
- decrement_i  in  1  lag pulse from the phase detector (−1).
- threshold_i  in  WIDTH-1  unsigned K; a value of 0 is treated as 1.
- initialValue_i  in  WIDTH  signed reload value.
- triggeredMax_o  out  1  registered one-cycle carry pulse (walk hit +K).
- triggeredMin_o  out  1  registered one-cycle borrow pulse (walk hit −K).
- counter_o  out  WIDTH  signed current walk value.
- locked_o  out  1  registered lock flag.

## Operation
- Reset (reset_i=0): counter 0, both trigger outputs 0, quiet counter 0, locked_o 0.
- Step is +1 if increment_i&!decrement_i, −1 if decrement_i&!increment_i, otherwise 0. Simultaneous pulses cancel and do not count as an event.
- Effective K: Keff = max(threshold_i,1).
- Reload value: initialValue_i if |initialValue_i| < Keff, else 0.
- Arithmetic: next = counter + step, evaluated at WIDTH+1 bits signed, so there is no wrap-around.
- When enable_i=1 and clear_i=0:
  - next ≥ Keff: counter ← reload, triggeredMax_o ← 1.
  - next ≤ −Keff: counter ← reload, triggeredMin_o ← 1.
  - Otherwise: counter ← next, both triggers ← 0.
- Comparison runs on every enabled cycle, including step 0. If K is lowered below |counter|, the next enabled cycle triggers in the direction of the counter's sign.
- When enable_i=0: counter, quiet counter and locked_o hold; trigger outputs ← 0.
- clear_i=1: counter ← reload, triggers ← 0, quiet counter ← 0, locked_o ← 0. This applies regardless of enable_i.
- Lock detector:
  - An event is an enabled, non-clear cycle with step ≠ 0.
  - On a trigger cycle, the quiet counter ← 0 (the trigger wins over the event).
  - Otherwise, each event increments the quiet counter, saturating at LOCK_WINDOW.
  - locked_o ← (quiet counter next-state == LOCK_WINDOW).

## Timing
- Inputs are sampled at edge N. counter_o, triggers and locked_o reflect that sample after edge N, giving 1-cycle latency.
- Trigger pulses last exactly one cycle per threshold crossing. Back-to-back triggers are possible only if the reload value is at ±(Keff−1).
- locked_o falls in the same cycle that a trigger pulse is high.
- threshold_i and initialValue_i are used combinationally each cycle and take effect at the next edge.
- Reset assertion clears all outputs immediately (asynchronous). Deassertion must be synchronised upstream.

## Structure
- Shared package loop_filter_pkg holds:
  - step_t enum {STEP_NONE, STEP_UP, STEP_DOWN};
  - the step-decode function;
  - the reload-clamp function.
- A single sub-module, lock_detector (parameter LOCK_WINDOW; inputs event, trigger, clear, enable; output locked), holds the quiet counter.
- Counter, compare and trigger registers live in the top module.

## Test plan
- WIDTH=5, K=8, init=0, eight increments → counter 1..7, then triggeredMax_o high one cycle after the 8th increment, counter_o=0.
- K=8, init=3, eleven decrements → triggeredMin_o pulse after the 11th decrement (counter reaches −7, next −8), counter_o=3.
- Inc and dec both high for 20 cycles → counter unchanged, no triggers, quiet counter unchanged.
- LOCK_WINDOW=4, K=8, alternating inc/dec for 4 events → locked_o=1 after the 4th event. A subsequent 8-increment run from 0 drops locked_o with the carry pulse.
- Counter at 6, threshold_i switched 8→4, enable_i=1, no steps → triggeredMax_o next cycle, counter_o=reload.
- init=9 with K=8 → reload clamps to 0. clear_i asserted mid-run → counter 0, locked_o 0. Reset mid-run → all outputs 0 asynchronously.

Source files
------------

// File: rtl/loop_filter_pkg.sv
// Shared types and helpers for the random-walk loop filter.
package loop_filter_pkg;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DOWN
    } step_t;

    // Lead/lag decode: simultaneous pulses cancel out.
    function automatic step_t decode_step(input logic inc, input logic dec);
        if (inc && !dec) begin
            return STEP_UP;
        end else if (dec && !inc) begin
            return STEP_DOWN;
        end
        return STEP_NONE;
    endfunction

    // Reload clamp: the start value is only usable when it lies strictly
    // inside the walk window (-keff, +keff); otherwise the walk restarts at 0.
    function automatic logic reload_clamp_ok(input int value, input int keff);
        int mag;
        mag = (value < 0) ? -value : value;
        return (mag < keff);
    endfunction

endpackage

// File: rtl/lock_detector.sv
// Counts quiet phase events (no carry/borrow) and flags lock once
// LOCK_WINDOW of them have passed in a row.
module lock_detector
    import loop_filter_pkg::*;
#(
    parameter int LOCK_WINDOW = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic evt,
    input  logic trigger,
    input  logic clear,
    input  logic enable,
    output logic locked
);

    localparam int QW = $clog2(LOCK_WINDOW + 1);
    localparam logic [QW-1:0] WINDOW = QW'(LOCK_WINDOW);

    logic [QW-1:0] quiet;
    logic [QW-1:0] quiet_next;

    // Next quiet count: a trigger restarts the window, events saturate at WINDOW.
    always_comb begin
        quiet_next = quiet;
        if (trigger) begin
            quiet_next = '0;
        end else if (evt && (quiet < WINDOW)) begin
            quiet_next = quiet + QW'(1);
        end
    end

    // Quiet counter and registered lock flag; clear wins over enable.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            quiet  <= '0;
            locked <= 1'b0;
        end else if (clear) begin
            quiet  <= '0;
            locked <= 1'b0;
        end else if (enable) begin
            quiet  <= quiet_next;
            locked <= (quiet_next == WINDOW);
        end
    end

endmodule

// File: rtl/random_walk_filter.sv
// Random-walk (K-counter) loop filter: integrates lead/lag pulses and emits
// one-cycle carry/borrow pulses when the walk reaches +/-K, then reloads.
module random_walk_filter
    import loop_filter_pkg::*;
#(
    parameter int WIDTH       = 5,
    parameter int LOCK_WINDOW = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    increment_i,
    input  logic                    decrement_i,
    input  logic        [WIDTH-2:0] threshold_i,
    input  logic signed [WIDTH-1:0] initialValue_i,
    output logic                    triggeredMax_o,
    output logic                    triggeredMin_o,
    output logic signed [WIDTH-1:0] counter_o,
    output logic                    locked_o
);

    step_t                  step;
    logic        [WIDTH-2:0] keff;
    logic signed [WIDTH:0]   keff_s;
    logic signed [WIDTH:0]   step_s;
    logic signed [WIDTH:0]   next_s;
    logic signed [WIDTH-1:0] reload;
    logic                    hit_max;
    logic                    hit_min;
    logic                    active;
    logic                    trigger;
    logic                    evt;

    // Decode the step, effective K and reload value, and compare one bit wider
    // than the counter so the walk can never wrap.
    always_comb begin
        step    = decode_step(increment_i, decrement_i);
        keff    = (threshold_i == '0) ? (WIDTH-1)'(1) : threshold_i;
        keff_s  = $signed({2'b00, keff});
        unique case (step)
            STEP_UP:   step_s = (WIDTH+1)'(1);
            STEP_DOWN: step_s = -(WIDTH+1)'(1);
            default:   step_s = '0;
        endcase
        next_s  = {counter_o[WIDTH-1], counter_o} + step_s;
        reload  = reload_clamp_ok(int'(initialValue_i), int'(keff)) ? initialValue_i : '0;
        hit_max = (next_s >= keff_s);
        hit_min = (next_s <= -keff_s);
        active  = enable_i && !clear_i;
        trigger = active && (hit_max || hit_min);
        evt     = active && (step != STEP_NONE);
    end

    // Walk counter and carry/borrow pulse registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            counter_o      <= '0;
            triggeredMax_o <= 1'b0;
            triggeredMin_o <= 1'b0;
        end else if (clear_i) begin
            counter_o      <= reload;
            triggeredMax_o <= 1'b0;
            triggeredMin_o <= 1'b0;
        end else if (enable_i) begin
            if (hit_max) begin
                counter_o      <= reload;
                triggeredMax_o <= 1'b1;
                triggeredMin_o <= 1'b0;
            end else if (hit_min) begin
                counter_o      <= reload;
                triggeredMax_o <= 1'b0;
                triggeredMin_o <= 1'b1;
            end else begin
                counter_o      <= next_s[WIDTH-1:0];
                triggeredMax_o <= 1'b0;
                triggeredMin_o <= 1'b0;
            end
        end else begin
            triggeredMax_o <= 1'b0;
            triggeredMin_o <= 1'b0;
        end
    end

    lock_detector #(
        .LOCK_WINDOW(LOCK_WINDOW)
    ) u_lock (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .evt    (evt),
        .trigger(trigger),
        .clear  (clear_i),
        .enable (enable_i),
        .locked (locked_o)
    );

endmodule

// File: tb/tb_random_walk_filter.sv
// Testbench for random_walk_filter: directed scenarios plus randomized
// stimulus against an integer-level reference model.
module tb_random_walk_filter;

    localparam int WIDTH = 5;
    localparam int LW    = 4;

    logic                    clk_i = 1'b0;
    logic                    reset_i;
    logic                    clear_i;
    logic                    enable_i;
    logic                    increment_i;
    logic                    decrement_i;
    logic        [WIDTH-2:0] threshold_i;
    logic signed [WIDTH-1:0] initialValue_i;
    logic                    triggeredMax_o;
    logic                    triggeredMin_o;
    logic signed [WIDTH-1:0] counter_o;
    logic                    locked_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_cnt  = 0;
    int m_q    = 0;
    int m_max  = 0;
    int m_min  = 0;
    int m_lock = 0;

    random_walk_filter #(
        .WIDTH(WIDTH),
        .LOCK_WINDOW(LW)
    ) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .clear_i       (clear_i),
        .enable_i      (enable_i),
        .increment_i   (increment_i),
        .decrement_i   (decrement_i),
        .threshold_i   (threshold_i),
        .initialValue_i(initialValue_i),
        .triggeredMax_o(triggeredMax_o),
        .triggeredMin_o(triggeredMin_o),
        .counter_o     (counter_o),
        .locked_o      (locked_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_q = 0; m_max = 0; m_min = 0; m_lock = 0;
    endtask

    // Spec-level behaviour of one clock edge with the given inputs.
    task automatic model_step(input int inc, input int dec, input int en,
                              input int clr, input int thr, input int init);
        int st, keff, rl, nxt, trig;
        st   = (inc != 0 && dec == 0) ? 1 : ((dec != 0 && inc == 0) ? -1 : 0);
        keff = (thr == 0) ? 1 : thr;
        rl   = (((init < 0) ? -init : init) < keff) ? init : 0;
        if (clr != 0) begin
            m_cnt = rl; m_max = 0; m_min = 0; m_q = 0; m_lock = 0;
        end else if (en != 0) begin
            nxt  = m_cnt + st;
            trig = 1;
            if (nxt >= keff) begin
                m_cnt = rl; m_max = 1; m_min = 0;
            end else if (nxt <= -keff) begin
                m_cnt = rl; m_max = 0; m_min = 1;
            end else begin
                m_cnt = nxt; m_max = 0; m_min = 0; trig = 0;
            end
            if (trig != 0) m_q = 0;
            else if (st != 0 && m_q < LW) m_q = m_q + 1;
            m_lock = (m_q == LW) ? 1 : 0;
        end else begin
            m_max = 0; m_min = 0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_cnt"}, int'(counter_o), m_cnt);
        check({tag, "_max"}, int'(triggeredMax_o), m_max);
        check({tag, "_min"}, int'(triggeredMin_o), m_min);
        check({tag, "_lock"}, int'(locked_o), m_lock);
    endtask

    // Apply one cycle of inputs, advance the model, compare after the edge.
    task automatic drive(input string tag, input int inc, input int dec, input int en,
                         input int clr, input int thr, input int init);
        logic [31:0] tv;
        logic [31:0] iv;
        tv = thr;
        iv = init;
        increment_i    = (inc != 0);
        decrement_i    = (dec != 0);
        enable_i       = (en != 0);
        clear_i        = (clr != 0);
        threshold_i    = tv[WIDTH-2:0];
        initialValue_i = iv[WIDTH-1:0];
        @(posedge clk_i);
        model_step(inc, dec, en, clr, thr, init);
        #1;
        compare_all(tag);
    endtask

    initial begin
        int r_thr, r_init, r_en, r_clr, r_inc, r_dec;
        reset_i = 1'b0; clear_i = 1'b0; enable_i = 1'b0;
        increment_i = 1'b0; decrement_i = 1'b0;
        threshold_i = '0; initialValue_i = '0;
        model_reset();
        #12;
        compare_all("reset");
        reset_i = 1'b1;
        @(posedge clk_i); #1;

        // Carry after eight increments with K=8, init=0
        drive("tp1_clr", 0, 0, 1, 1, 8, 0);
        for (int i = 1; i <= 7; i++) begin
            drive("tp1", 1, 0, 1, 0, 8, 0);
            check("tp1_walk", int'(counter_o), i);
        end
        drive("tp1", 1, 0, 1, 0, 8, 0);
        check("tp1_carry", int'(triggeredMax_o), 1);
        check("tp1_reload", int'(counter_o), 0);
        drive("tp1_after", 0, 0, 1, 0, 8, 0);
        check("tp1_pulse1", int'(triggeredMax_o), 0);

        // Borrow after eleven decrements from init=3
        drive("tp2_clr", 0, 0, 1, 1, 8, 3);
        check("tp2_start", int'(counter_o), 3);
        for (int i = 1; i <= 10; i++) drive("tp2", 0, 1, 1, 0, 8, 3);
        check("tp2_m7", int'(counter_o), -7);
        drive("tp2", 0, 1, 1, 0, 8, 3);
        check("tp2_borrow", int'(triggeredMin_o), 1);
        check("tp2_reload", int'(counter_o), 3);

        // Simultaneous pulses cancel
        for (int i = 0; i < 20; i++) drive("tp3", 1, 1, 1, 0, 8, 3);
        check("tp3_hold", int'(counter_o), 3);

        // Lock after four alternating events, lost on carry
        drive("tp4_clr", 0, 0, 1, 1, 8, 0);
        for (int i = 0; i < 4; i++) drive("tp4", (i % 2 == 0) ? 1 : 0, (i % 2 == 0) ? 0 : 1, 1, 0, 8, 0);
        check("tp4_locked", int'(locked_o), 1);
        for (int i = 0; i < 7; i++) drive("tp4_run", 1, 0, 1, 0, 8, 0);
        check("tp4_still", int'(locked_o), 1);
        drive("tp4_run", 1, 0, 1, 0, 8, 0);
        check("tp4_drop", int'(locked_o), 0);
        check("tp4_carry", int'(triggeredMax_o), 1);

        // Lowering K below the counter triggers on a no-step cycle
        for (int i = 0; i < 6; i++) drive("tp5", 1, 0, 1, 0, 8, 0);
        check("tp5_six", int'(counter_o), 6);
        drive("tp5", 0, 0, 1, 0, 4, 0);
        check("tp5_carry", int'(triggeredMax_o), 1);
        check("tp5_reload", int'(counter_o), 0);

        // Disabled cycles hold the walk; threshold 0 acts as 1
        drive("hold", 1, 0, 1, 0, 8, 0);
        for (int i = 0; i < 3; i++) drive("hold", 1, 0, 0, 0, 8, 0);
        check("hold_cnt", int'(counter_o), 1);
        drive("k0", 0, 0, 1, 0, 0, 0);
        check("k0_carry", int'(triggeredMax_o), 1);

        // Reload clamp, mid-run clear, mid-run async reset
        drive("tp6_clr", 0, 0, 1, 1, 8, 9);
        check("tp6_clamp", int'(counter_o), 0);
        for (int i = 0; i < 5; i++) drive("tp6", 1, 0, 1, 0, 8, 2);
        drive("tp6_clr2", 1, 0, 0, 1, 8, -7);
        check("tp6_clrval", int'(counter_o), -7);
        check("tp6_clrlock", int'(locked_o), 0);
        for (int i = 0; i < 3; i++) drive("tp6", 1, 0, 1, 0, 8, 0);
        reset_i = 1'b0;
        #2;
        model_reset();
        check("arst_cnt", int'(counter_o), 0);
        compare_all("arst");
        #1;
        reset_i = 1'b1;

        // Randomized run
        r_thr = 8; r_init = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) r_thr = $urandom_range(0, 15);
            if ($urandom_range(0, 15) == 0) r_init = int'($urandom_range(0, 31)) - 16;
            r_en  = ($urandom_range(0, 9) != 0) ? 1 : 0;
            r_clr = ($urandom_range(0, 39) == 0) ? 1 : 0;
            r_inc = $urandom_range(0, 1);
            r_dec = $urandom_range(0, 1);
            drive("rnd", r_inc, r_dec, r_en, r_clr, r_thr, r_init);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
